// File: rtl/riscv_defines.sv
// Shared RISC-V encodings: ALU operation codes and next-PC select codes.
package riscv_defines;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [1:0] NEXT_PC_PC_PLUS_4          = 2'd0;
  localparam logic [1:0] NEXT_PC_BRANCH_JUMP_TARGET = 2'd1;
  localparam logic [1:0] NEXT_PC_JALR_TARGET        = 2'd2;

endpackage

// File: rtl/riscv_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// slave: the decode stage itself; master: the surrounding fetch/execute logic.
interface riscv_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            flush;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [31:0]     out_imm;
  logic [3:0]      out_alu_op;
  logic            out_alu_src_imm;
  logic            out_alu_src_pc;
  logic            out_reg_write;
  logic            out_mem_read;
  logic            out_mem_write;
  logic [2:0]      out_funct3;
  logic            out_branch;
  logic [1:0]      out_next_pc_sel;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
           out_alu_op, out_alu_src_imm, out_alu_src_pc, out_reg_write,
           out_mem_read, out_mem_write, out_funct3, out_branch,
           out_next_pc_sel, out_illegal
  );

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
           out_alu_op, out_alu_src_imm, out_alu_src_pc, out_reg_write,
           out_mem_read, out_mem_write, out_funct3, out_branch,
           out_next_pc_sel, out_illegal
  );
endinterface

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word into one
// output pipeline register, with a single-bubble load-use interlock.
module riscv_decode_stage
  import riscv_defines::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  riscv_decode_stage_if.slave bus
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0]  arith_op;
  logic        bad;

  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [31:0] d_imm;
  logic [3:0]  d_alu_op;
  logic        d_src_imm, d_src_pc, d_reg_write, d_mem_read, d_mem_write;
  logic [2:0]  d_funct3;
  logic        d_branch;
  logic [1:0]  d_next_pc_sel;
  logic        d_illegal;

  logic        hazard;
  logic        accept;

  // Decode the presented word; unused register fields are forced to 0.
  always_comb begin
    opcode = bus.in_instr[6:0];
    f3     = bus.in_instr[14:12];
    f7     = bus.in_instr[31:25];
    imm_i  = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
    imm_s  = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
    imm_b  = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
              bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
    imm_u  = {bus.in_instr[31:12], 12'b0};
    imm_j  = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
              bus.in_instr[20], bus.in_instr[30:21], 1'b0};

    case (f3)
      3'b000:  arith_op = ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase

    bad           = 1'b0;
    d_rs1         = 5'd0;
    d_rs2         = 5'd0;
    d_rd          = 5'd0;
    d_imm         = 32'd0;
    d_alu_op      = ALU_ADD;
    d_src_imm     = 1'b0;
    d_src_pc      = 1'b0;
    d_reg_write   = 1'b0;
    d_mem_read    = 1'b0;
    d_mem_write   = 1'b0;
    d_funct3      = 3'd0;
    d_branch      = 1'b0;
    d_next_pc_sel = NEXT_PC_PC_PLUS_4;

    case (opcode)
      OPC_OP: begin
        d_rs1       = bus.in_instr[19:15];
        d_rs2       = bus.in_instr[24:20];
        d_rd        = bus.in_instr[11:7];
        d_funct3    = f3;
        d_reg_write = 1'b1;
        d_alu_op    = arith_op;
        if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      d_alu_op = ALU_SUB;
          else if (f3 == 3'b101) d_alu_op = ALU_SRA;
          else                   bad = 1'b1;
        end else if (f7 != 7'b0000000) begin
          bad = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        d_rs1       = bus.in_instr[19:15];
        d_rd        = bus.in_instr[11:7];
        d_imm       = imm_i;
        d_src_imm   = 1'b1;
        d_funct3    = f3;
        d_reg_write = 1'b1;
        d_alu_op    = arith_op;
        if (f3 == 3'b001 && f7 != 7'b0000000) begin
          bad = 1'b1;
        end else if (f3 == 3'b101) begin
          if (f7 == 7'b0100000)      d_alu_op = ALU_SRA;
          else if (f7 != 7'b0000000) bad = 1'b1;
        end
      end
      OPC_LOAD: begin
        d_rs1       = bus.in_instr[19:15];
        d_rd        = bus.in_instr[11:7];
        d_imm       = imm_i;
        d_src_imm   = 1'b1;
        d_funct3    = f3;
        d_mem_read  = 1'b1;
        d_reg_write = 1'b1;
      end
      OPC_STORE: begin
        d_rs1       = bus.in_instr[19:15];
        d_rs2       = bus.in_instr[24:20];
        d_imm       = imm_s;
        d_src_imm   = 1'b1;
        d_funct3    = f3;
        d_mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        d_rs1         = bus.in_instr[19:15];
        d_rs2         = bus.in_instr[24:20];
        d_imm         = imm_b;
        d_funct3      = f3;
        d_branch      = 1'b1;
        d_next_pc_sel = NEXT_PC_BRANCH_JUMP_TARGET;
        case (f3[2:1])
          2'b00:   d_alu_op = ALU_SUB;
          2'b10:   d_alu_op = ALU_SLT;
          2'b11:   d_alu_op = ALU_SLTU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LUI: begin
        d_rd        = bus.in_instr[11:7];
        d_imm       = imm_u;
        d_src_imm   = 1'b1;
        d_alu_op    = ALU_PASS_B;
        d_reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        d_rd        = bus.in_instr[11:7];
        d_imm       = imm_u;
        d_src_imm   = 1'b1;
        d_src_pc    = 1'b1;
        d_reg_write = 1'b1;
      end
      OPC_JAL: begin
        d_rd          = bus.in_instr[11:7];
        d_imm         = imm_j;
        d_reg_write   = 1'b1;
        d_next_pc_sel = NEXT_PC_BRANCH_JUMP_TARGET;
      end
      OPC_JALR: begin
        d_rs1         = bus.in_instr[19:15];
        d_rd          = bus.in_instr[11:7];
        d_imm         = imm_i;
        d_src_imm     = 1'b1;
        d_funct3      = f3;
        d_reg_write   = 1'b1;
        d_next_pc_sel = NEXT_PC_JALR_TARGET;
        if (f3 != 3'b000) bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase

    // Illegal words travel down as inert bubbles carrying only pc and the flag.
    d_illegal = bad;
    if (bad) begin
      d_rs1         = 5'd0;
      d_rs2         = 5'd0;
      d_rd          = 5'd0;
      d_imm         = 32'd0;
      d_alu_op      = ALU_ADD;
      d_src_imm     = 1'b0;
      d_src_pc      = 1'b0;
      d_reg_write   = 1'b0;
      d_mem_read    = 1'b0;
      d_mem_write   = 1'b0;
      d_funct3      = 3'd0;
      d_branch      = 1'b0;
      d_next_pc_sel = NEXT_PC_PC_PLUS_4;
    end
  end

  // d_rs1/d_rs2 are already 0 when the field is unused, and out_rd!=0 is
  // required, so a plain index compare covers the uses_rs1/uses_rs2 terms.
  assign hazard = bus.out_valid && bus.out_mem_read && (bus.out_rd != 5'd0) &&
                  ((d_rs1 == bus.out_rd) || (d_rs2 == bus.out_rd));

  assign bus.in_ready = !hazard && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Output pipeline register; flush wins over accept, otherwise it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid       <= 1'b0;
      bus.out_pc          <= RESET_PC;
      bus.out_rs1         <= 5'd0;
      bus.out_rs2         <= 5'd0;
      bus.out_rd          <= 5'd0;
      bus.out_imm         <= 32'd0;
      bus.out_alu_op      <= ALU_ADD;
      bus.out_alu_src_imm <= 1'b0;
      bus.out_alu_src_pc  <= 1'b0;
      bus.out_reg_write   <= 1'b0;
      bus.out_mem_read    <= 1'b0;
      bus.out_mem_write   <= 1'b0;
      bus.out_funct3      <= 3'd0;
      bus.out_branch      <= 1'b0;
      bus.out_next_pc_sel <= NEXT_PC_PC_PLUS_4;
      bus.out_illegal     <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid       <= 1'b1;
      bus.out_pc          <= bus.in_pc;
      bus.out_rs1         <= d_rs1;
      bus.out_rs2         <= d_rs2;
      bus.out_rd          <= d_rd;
      bus.out_imm         <= d_imm;
      bus.out_alu_op      <= d_alu_op;
      bus.out_alu_src_imm <= d_src_imm;
      bus.out_alu_src_pc  <= d_src_pc;
      bus.out_reg_write   <= d_reg_write;
      bus.out_mem_read    <= d_mem_read;
      bus.out_mem_write   <= d_mem_write;
      bus.out_funct3      <= d_funct3;
      bus.out_branch      <= d_branch;
      bus.out_next_pc_sel <= d_next_pc_sel;
      bus.out_illegal     <= d_illegal;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Scoreboard bench for riscv_decode_stage: directed scenarios followed by
// randomized traffic, all checked against a rule-level decode model.
module tb_riscv_decode_stage;
  import riscv_defines::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        src_imm;
    logic        src_pc;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        branch;
    logic [1:0]  npc;
    logic        illegal;
  } dec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_decode_stage_if bus ();

  riscv_decode_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  dec_t q[$];
  bit   mv = 1'b0;
  dec_t held;
  dec_t snap;
  dec_t exp_d;
  dec_t rst_exp;
  bit   stalled = 1'b0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s timeout t=%0t", nm, $time);
  endtask

  // Rule-level decode: fields and immediates straight from the ISA tables.
  function automatic dec_t ref_decode(input logic [31:0] pc, input logic [31:0] w);
    dec_t d;
    logic [3:0] tbl [8];
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok;
    tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    f3 = w[14:12];
    f7 = w[31:25];
    d = '0;
    d.pc = pc;
    d.alu_op = ALU_ADD;
    d.npc = NEXT_PC_PC_PLUS_4;
    ok = 1'b1;
    case (w[6:0])
      7'h33: begin
        d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7];
        d.funct3 = f3; d.reg_write = 1'b1; d.alu_op = tbl[f3];
        if (f7 == 7'h20 && f3 == 3'd0) d.alu_op = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) d.alu_op = ALU_SRA;
        else if (f7 != 7'h00) ok = 1'b0;
      end
      7'h13: begin
        d.rs1 = w[19:15]; d.rd = w[11:7]; d.funct3 = f3;
        d.imm = $signed(w) >>> 20;
        d.src_imm = 1'b1; d.reg_write = 1'b1; d.alu_op = tbl[f3];
        if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
        if (f3 == 3'd5 && f7 == 7'h20) d.alu_op = ALU_SRA;
        else if (f3 == 3'd5 && f7 != 7'h00) ok = 1'b0;
      end
      7'h03: begin
        d.rs1 = w[19:15]; d.rd = w[11:7]; d.funct3 = f3;
        d.imm = $signed(w) >>> 20;
        d.src_imm = 1'b1; d.mem_read = 1'b1; d.reg_write = 1'b1;
      end
      7'h23: begin
        d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.funct3 = f3;
        d.imm = $signed({w[31:25], w[11:7], 20'b0}) >>> 20;
        d.src_imm = 1'b1; d.mem_write = 1'b1;
      end
      7'h63: begin
        d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.funct3 = f3;
        d.imm = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0, 19'b0}) >>> 19;
        d.branch = 1'b1; d.npc = NEXT_PC_BRANCH_JUMP_TARGET;
        if (f3 == 3'd0 || f3 == 3'd1) d.alu_op = ALU_SUB;
        else if (f3 == 3'd4 || f3 == 3'd5) d.alu_op = ALU_SLT;
        else if (f3 == 3'd6 || f3 == 3'd7) d.alu_op = ALU_SLTU;
        else ok = 1'b0;
      end
      7'h37: begin
        d.rd = w[11:7]; d.imm = {w[31:12], 12'b0};
        d.src_imm = 1'b1; d.alu_op = ALU_PASS_B; d.reg_write = 1'b1;
      end
      7'h17: begin
        d.rd = w[11:7]; d.imm = {w[31:12], 12'b0};
        d.src_imm = 1'b1; d.src_pc = 1'b1; d.reg_write = 1'b1;
      end
      7'h6F: begin
        d.rd = w[11:7];
        d.imm = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0, 11'b0}) >>> 11;
        d.reg_write = 1'b1; d.npc = NEXT_PC_BRANCH_JUMP_TARGET;
      end
      7'h67: begin
        d.rs1 = w[19:15]; d.rd = w[11:7]; d.funct3 = f3;
        d.imm = $signed(w) >>> 20;
        d.src_imm = 1'b1; d.reg_write = 1'b1; d.npc = NEXT_PC_JALR_TARGET;
        if (f3 != 3'd0) ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d = '0;
      d.pc = pc;
      d.alu_op = ALU_ADD;
      d.npc = NEXT_PC_PC_PLUS_4;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  function automatic logic ref_ready();
    dec_t d;
    logic haz;
    d = ref_decode(bus.in_pc, bus.in_instr);
    haz = mv && held.mem_read && (held.rd != 5'd0) &&
          ((d.rs1 == held.rd) || (d.rs2 == held.rd));
    return !haz && (!mv || bus.out_ready);
  endfunction

  function automatic dec_t dut_out();
    dec_t o;
    o.pc = bus.out_pc; o.rs1 = bus.out_rs1; o.rs2 = bus.out_rs2; o.rd = bus.out_rd;
    o.imm = bus.out_imm; o.alu_op = bus.out_alu_op;
    o.src_imm = bus.out_alu_src_imm; o.src_pc = bus.out_alu_src_pc;
    o.reg_write = bus.out_reg_write; o.mem_read = bus.out_mem_read;
    o.mem_write = bus.out_mem_write; o.funct3 = bus.out_funct3;
    o.branch = bus.out_branch; o.npc = bus.out_next_pc_sel; o.illegal = bus.out_illegal;
    return o;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0] opcs [9];
    int k;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    w = $urandom();
    k = $urandom_range(0, 10);
    if (k > 8) return w;
    w[6:0]   = opcs[k];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    if (k <= 1) begin
      case ($urandom_range(0, 3))
        0, 1:    w[31:25] = 7'h00;
        2:       w[31:25] = 7'h20;
        default: ;
      endcase
    end
    if (k == 8 && $urandom_range(0, 3) != 0) w[14:12] = 3'd0;
    return w;
  endfunction

  // Reference pipeline: what is held, and what the scoreboard expects next.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mv = 1'b0;
        q.delete();
      end else if (bus.flush) begin
        if (mv && !bus.out_ready) q.delete();
        mv = 1'b0;
      end else if (bus.in_valid && ref_ready()) begin
        held = ref_decode(bus.in_pc, bus.in_instr);
        q.push_back(held);
        mv = 1'b1;
      end else if (bus.out_ready) begin
        mv = 1'b0;
      end
    end
  end

  // Monitor: handshake state, stability under backpressure, scoreboard pops.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("in_ready", bus.in_ready, ref_ready());
        check("out_valid", bus.out_valid, mv);
        if (bus.out_valid && stalled) check("hold_stable", dut_out(), snap);
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            bound_fail("scoreboard_empty");
          end else begin
            exp_d = q.pop_front();
            check("decode", dut_out(), exp_d);
          end
        end
        stalled = bus.out_valid && !bus.out_ready;
        snap = dut_out();
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic send(input logic [31:0] pc, input logic [31:0] w, output int stalls);
    bit done;
    done = 1'b0;
    stalls = 0;
    bus.in_valid = 1'b1;
    bus.in_pc = pc;
    bus.in_instr = w;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) bound_fail("send");
  endtask

  task automatic wait_out(output dec_t o, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    o = '0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) begin
        o = dut_out();
        got = 1'b1;
      end
    end
    if (!got) bound_fail("wait_out");
    @(posedge clk);
    #1;
  endtask

  initial begin
    dec_t o;
    int st, lat;
    logic [31:0] ill [3];
    ill = '{32'h0000_007F, 32'h4000_1033, 32'hFFFF_FFFF};
    rst_exp = '0;
    rst_exp.alu_op = ALU_ADD;
    rst_exp.npc = NEXT_PC_PC_PLUS_4;

    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    #12;
    check("reset_valid", bus.out_valid, 1'b0);
    check("reset_outputs", dut_out(), rst_exp);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    send(32'h100, 32'h0050_0093, st);
    wait_out(o, lat);
    check("addi_latency", lat, 1);
    check("addi_pc", o.pc, 32'h100);
    check("addi_rd", o.rd, 5'd1);
    check("addi_rs1", o.rs1, 5'd0);
    check("addi_imm", o.imm, 32'd5);
    check("addi_alu", o.alu_op, ALU_ADD);
    check("addi_src_imm", o.src_imm, 1'b1);
    check("addi_reg_write", o.reg_write, 1'b1);

    bus.out_ready = 1'b0;
    send(32'h200, 32'h0010_8113, st);
    fork
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join_none
    send(32'h204, 32'h0020_81B3, st);
    check("bp_stall_cycles", st, 3);
    wait_out(o, lat);
    check("bp_second_pc", o.pc, 32'h204);

    send(32'h300, 32'h0000_A283, st);
    send(32'h304, 32'h0022_8333, st);
    check("loaduse_bubble", st, 1);
    send(32'h308, 32'h0000_A283, st);
    send(32'h30C, 32'h0020_0333, st);
    check("no_dep_no_bubble", st, 0);
    wait_out(o, lat);

    send(32'h400, 32'hFE00_0EE3, st);
    wait_out(o, lat);
    check("beq_imm", o.imm, 32'hFFFF_FFFC);
    check("beq_npc", o.npc, NEXT_PC_BRANCH_JUMP_TARGET);
    check("beq_branch", o.branch, 1'b1);
    send(32'h404, 32'h0010_00EF, st);
    wait_out(o, lat);
    check("jal_imm", o.imm, 32'h0000_0800);
    check("jal_npc", o.npc, NEXT_PC_BRANCH_JUMP_TARGET);
    send(32'h408, 32'h1234_5137, st);
    wait_out(o, lat);
    check("lui_imm", o.imm, 32'h1234_5000);
    check("lui_alu", o.alu_op, ALU_PASS_B);

    bus.flush = 1'b1;
    send(32'h500, 32'h0050_0093, st);
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_kill", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    send(32'h504, 32'h0070_0193, st);
    wait_out(o, lat);
    check("after_flush_pc", o.pc, 32'h504);
    check("after_flush_rd", o.rd, 5'd3);

    foreach (ill[i]) begin
      send(32'h600 + 32'(i * 4), ill[i], st);
      wait_out(o, lat);
      check("illegal_flag", o.illegal, 1'b1);
      check("illegal_enables", {o.reg_write, o.mem_read, o.mem_write, o.branch}, 4'b0);
    end

    bus.out_ready = 1'b0;
    send(32'h700, 32'h0050_0093, st);
    bus.in_valid = 1'b1; bus.in_pc = 32'h704; bus.in_instr = 32'h0010_8113;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("midstall_reset_valid", bus.out_valid, 1'b0);
    check("midstall_reset_outputs", dut_out(), rst_exp);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h800, 32'h0050_0093, st);
    wait_out(o, lat);
    check("post_reset_pc", o.pc, 32'h800);

    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_instr  = gen_instr();
      bus.in_pc     = $urandom() & 32'hFFFF_FFFC;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 19) == 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule
